// File: rtl/clk_div.sv
// Programmable integer clock divider / strobe generator.
// Output is high for the first DUTY_TIME cycles of every PERIOD-cycle window,
// driven straight from a flop so it is glitch-free and safe as a clock enable.
module clk_div #(
  parameter int PERIOD    = 5,
  parameter int DUTY_TIME = 1
) (
  input  logic clk,
  input  logic reset,
  output logic clk_div2
);

  // Counter just wide enough to hold 0..PERIOD-1 (at least one bit).
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  // Duty values above PERIOD behave exactly like PERIOD (always high).
  localparam int unsigned DUTY_CL_I = (DUTY_TIME > PERIOD) ? PERIOD :
                                      (DUTY_TIME < 0)      ? 0      : DUTY_TIME;

  // One extra bit so a duty equal to 2**CNT_W still compares correctly.
  localparam logic [CNT_W:0]   DUTY_CL  = (CNT_W+1)'(DUTY_CL_I);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((PERIOD > 0) ? PERIOD - 1 : 0);

  // Reject nonsensical configurations at elaboration time.
  if (PERIOD < 1) begin : g_bad_period
    $fatal(1, "clk_div: PERIOD must be >= 1 (got %0d)", PERIOD);
  end
  if (DUTY_TIME < 0) begin : g_bad_duty
    $fatal(1, "clk_div: DUTY_TIME must be >= 0 (got %0d)", DUTY_TIME);
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             out_nxt;

  // Next phase and next output level derived from the current phase.
  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    out_nxt = 1'b0;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
    end
    if ({1'b0, cnt} < DUTY_CL) begin
      out_nxt = 1'b1;
    end
  end

  // Phase counter and output flop; reset restarts the period at phase 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      clk_div2 <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      clk_div2 <= out_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div.sv
// Self-checking bench for clk_div: several parameterisations share one clock
// and reset, and every output is compared against an edge-count model.
module tb_clk_div;

  logic clk;
  logic reset;
  logic o51, o42, o30, o33, o11, o73, o35;

  int checks = 0;
  int errors = 0;

  // Edges seen since reset release; 0 while in reset.
  int k = 0;
  int edge_idx = 0;
  int last_rise = 0;
  bit have_rise = 0;
  logic prev73 = 1'b0;

  clk_div #(.PERIOD(5), .DUTY_TIME(1)) u51 (.clk(clk), .reset(reset), .clk_div2(o51));
  clk_div #(.PERIOD(4), .DUTY_TIME(2)) u42 (.clk(clk), .reset(reset), .clk_div2(o42));
  clk_div #(.PERIOD(3), .DUTY_TIME(0)) u30 (.clk(clk), .reset(reset), .clk_div2(o30));
  clk_div #(.PERIOD(3), .DUTY_TIME(3)) u33 (.clk(clk), .reset(reset), .clk_div2(o33));
  clk_div #(.PERIOD(1), .DUTY_TIME(1)) u11 (.clk(clk), .reset(reset), .clk_div2(o11));
  clk_div #(.PERIOD(7), .DUTY_TIME(3)) u73 (.clk(clk), .reset(reset), .clk_div2(o73));
  clk_div #(.PERIOD(3), .DUTY_TIME(5)) u35 (.clk(clk), .reset(reset), .clk_div2(o35));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output: the k-th edge after release sits at phase (k-1) mod p.
  function automatic logic exp_out(int p, int d);
    if (k == 0) return 1'b0;
    return (((k - 1) % p) < d) ? 1'b1 : 1'b0;
  endfunction

  // Expected phase counter value after k edges out of reset.
  function automatic int exp_cnt(int p);
    return k % p;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d, k=%0d)", tag, obs, expv, edge_idx, k);
    end
  endtask

  task automatic check_all();
    chk("p5d1", 32'(o51), 32'(exp_out(5, 1)));
    chk("p4d2", 32'(o42), 32'(exp_out(4, 2)));
    chk("p3d0", 32'(o30), 32'(exp_out(3, 0)));
    chk("p3d3", 32'(o33), 32'(exp_out(3, 3)));
    chk("p1d1", 32'(o11), 32'(exp_out(1, 1)));
    chk("p7d3", 32'(o73), 32'(exp_out(7, 3)));
    chk("p3d5", 32'(o35), 32'(exp_out(3, 5)));
    chk("cnt5", 32'(u51.cnt), 32'(exp_cnt(5)));
    chk("cnt7", 32'(u73.cnt), 32'(exp_cnt(7)));
    chk("cnt1", 32'(u11.cnt), 32'(exp_cnt(1)));
  endtask

  // One rising edge, model update, then check just after the edge.
  task automatic step();
    @(posedge clk);
    if (reset) k++;
    else k = 0;
    edge_idx++;
    #1;
    check_all();
    if (o73 === 1'b1 && prev73 === 1'b0) begin
      if (have_rise) chk("gap7", 32'(edge_idx - last_rise), 32'd7);
      last_rise = edge_idx;
      have_rise = 1'b1;
    end
    prev73 = o73;
  endtask

  // Change reset between edges; assertion must clear outputs immediately.
  task automatic set_reset(logic v);
    @(negedge clk);
    reset = v;
    if (!v) begin
      k = 0;
      have_rise = 1'b0;
      prev73 = 1'b0;
    end
    #1;
    check_all();
  endtask

  logic [9:0] seq51;
  logic [7:0] seq42;
  int highs;

  initial begin
    seq51 = 10'b1000010000;
    seq42 = 8'b11001100;
    reset = 1'b0;

    // Reset held low for 3 edges: everything stays at 0.
    for (int i = 0; i < 3; i++) step();

    // First period after release, against literal waveforms.
    set_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("seq51", 32'(o51), 32'(seq51[9-i]));
      if (i < 8) chk("seq42", 32'(o42), 32'(seq42[7-i]));
    end

    // Reset asserted before edge 3 of a period, held 2 edges, then a full period.
    step(); step();
    set_reset(1'b0);
    step(); step();
    set_reset(1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("restart51", 32'(o51), 32'(seq51[9-i]));
    end

    // Async assertion while outputs are high, release again.
    step();
    set_reset(1'b0);
    chk("async33", 32'(o33), 32'd0);
    step();
    set_reset(1'b1);

    // 50% duty over 100 edges.
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (o42 === 1'b1) highs++;
    end
    chk("highs42", 32'(highs), 32'd50);

    // Long run: rise spacing and counter bound checked inside step().
    for (int i = 0; i < 1000; i++) step();

    // Random run lengths and random reset pulses.
    for (int s = 0; s < 25; s++) begin
      int run_len;
      int hold;
      run_len = int'($urandom_range(1, 40));
      hold    = int'($urandom_range(1, 3));
      for (int i = 0; i < run_len; i++) step();
      set_reset(1'b0);
      for (int i = 0; i < hold; i++) step();
      set_reset(1'b1);
    end
    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
